layer_maxpool2x2: RTL and testbench
===================================

Name: layer_maxpool2x2

Overview:
- 2x2, stride-2 max-pooling stage for one feature-map channel, directly downstream of a layer-0 feature-map convolution block.
- Consumes that block's raster-order stream of IEEE-754 single-precision pixels (IMG_SIZE x IMG_SIZE).
- Emits a (IMG_SIZE/2) x (IMG_SIZE/2) raster-order stream to the next layer.
- Valid-only streaming, no backpressure; one half-row line buffer holds even-row pair maxima.

Parameters:
- DATA_WIDTH, 32, pixel width; IEEE-754 single precision.
- IMG_SIZE, 416, input width and height in pixels; must be even and at least 2.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel; sampled only when valid_in=1.
- valid_in  input  1  input pixel strobe; gaps of any length are allowed.
- data_out  output  DATA_WIDTH  pooled pixel.
- valid_out  output  1  one-cycle strobe per pooled pixel.
- frame_done  output  1  only when LAYER_MAXPOOL_FRAME_DONE_EN is defined; see Optional Feature.

Behaviour:
- Reset (Rst=0, asynchronous): col_cnt=0, row_cnt=0, pair_reg=0, data_out=0, valid_out=0, frame_done=0. Line-buffer contents are don't-care.
- Reset mid-frame: the frame is discarded. The first valid pixel after release is row 0, col 0.
- Counters:
  - col_cnt runs 0..IMG_SIZE-1 and advances on each valid_in.
  - At IMG_SIZE-1, col_cnt wraps to 0 and row_cnt increments.
  - row_cnt wraps from IMG_SIZE-1 to 0 (end of frame).
  - With valid_in=0 all state holds.
- Float max, fmax(a,b), combinational:
  - Signs differ: the operand with sign=0 wins.
  - Both sign=0: the larger {exp,mantissa} wins.
  - Both sign=1: the smaller {exp,mantissa} wins.
  - Equal bit patterns, or +0 vs -0: a wins. a is always the earlier-arriving operand.
  - NaN/Inf get no special treatment; they follow the rule above.
- Even col (col_cnt[0]=0): pair_reg <= data_in.
- Odd col, even row: linebuf[col_cnt>>1] <= fmax(pair_reg, data_in).
- Odd col, odd row, on the same edge:
  - data_out <= fmax(linebuf[col_cnt>>1], fmax(pair_reg, data_in)).
  - valid_out <= 1.
- In every other cycle valid_out <= 0; data_out holds its last value.
- Latency: valid_out rises on the edge that samples the bottom-right pixel of the window, i.e. 1 cycle after that pixel is presented.
- Output count: exactly (IMG_SIZE/2)^2 valid_out pulses per frame, in raster order. No output occurs on even rows.
- Back-to-back frames need no idle cycles. Row 0 of the next frame can follow the last pixel directly, because linebuf is rewritten before it is read.
- Line buffer: IMG_SIZE/2 entries x DATA_WIDTH, one write port and one read port. Read is an asynchronous (combinational) index or an equivalent bypass; no extra latency is allowed.

Optional Feature:
- Macro: LAYER_MAXPOOL_FRAME_DONE_EN.
- Defined:
  - Output port frame_done exists.
  - It pulses 1 cycle, coincident with valid_out, for the last pooled pixel of a frame: row_cnt=IMG_SIZE-1, col_cnt=IMG_SIZE-1.
  - Reset value is 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. IMG_SIZE=4, continuous valid. Row0 = 3F800000, 40000000, BF800000, C0000000. Row1 = 40400000, 3F800000, C0400000, BF000000. -> Two valid_out pulses, data_out 40400000 then BF000000, each 1 cycle after the row-1 odd-column pixel. No pulse during row 0.
2. Same frame with valid_in deasserted for 3 random cycles between every pixel -> same two outputs, same values. valid_out is a single-cycle pulse each time.
3. Tie and zero: a window of 80000000, 00000000, 00000000, 80000000 -> output 80000000 (first operand wins). A window of all 41200000 -> output 41200000.
4. Reset asserted after 5 pixels of a 4x4 frame, then a full fresh frame from test 1 -> no output before reset release. After release, exactly outputs 40400000, BF000000, and no stale line-buffer data.
5. IMG_SIZE=416, two back-to-back frames of ramp data (pixel = float(row*416+col)) -> 43264 pulses per frame. Each output equals float of its bottom-right input index. With LAYER_MAXPOOL_FRAME_DONE_EN defined, frame_done pulses exactly once per frame, on the last output.

Source files
------------

// File: rtl/layer_maxpool2x2.sv
// layer_maxpool2x2 -- 2x2 stride-2 max pooling over a raster stream of
// IEEE-754 single-precision pixels (one channel, IMG_SIZE x IMG_SIZE in,
// IMG_SIZE/2 x IMG_SIZE/2 out). Valid-only streaming, no backpressure.
// Even rows leave their horizontal pair maxima in a half-row line buffer;
// odd rows combine them with their own pair maxima to emit pooled pixels.
// Optional feature macro: LAYER_MAXPOOL_FRAME_DONE_EN adds a frame_done
// pulse on the last pooled pixel of each frame.
module layer_maxpool2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_SIZE   = 416
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
   ,
   output logic                  frame_done
`endif
);

   localparam int HALF   = IMG_SIZE / 2;
   localparam int CNT_W  = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
   localparam int ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

   // Float max on raw bit patterns. Ties (including +0 vs -0) go to a,
   // which callers always bind to the earlier-arriving operand.
   function automatic logic [DATA_WIDTH-1:0] fmax(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic                  sa, sb;
      logic [DATA_WIDTH-2:0] ma, mb;
      sa = a[DATA_WIDTH-1];
      sb = b[DATA_WIDTH-1];
      ma = a[DATA_WIDTH-2:0];
      mb = b[DATA_WIDTH-2:0];
      if ((ma == '0) && (mb == '0))
         return a;
      else if (sa != sb)
         return sa ? b : a;
      else if (!sa)
         return (mb > ma) ? b : a;
      else
         return (mb < ma) ? b : a;
   endfunction

   logic [CNT_W-1:0]      col_cnt_reg;
   logic [CNT_W-1:0]      row_cnt_reg;
   logic [DATA_WIDTH-1:0] pair_reg;
   logic [DATA_WIDTH-1:0] linebuf [0:HALF-1];

   logic [ADDR_W-1:0]     lb_addr;
   logic [DATA_WIDTH-1:0] lb_rd;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] win_max;
   logic                  odd_col;
   logic                  odd_row;
   logic                  last_col;
   logic                  last_row;

   // The line buffer is read combinationally so the window closes on the
   // same edge that samples its bottom-right pixel.
   assign lb_addr  = ADDR_W'(col_cnt_reg >> 1);
   assign lb_rd    = linebuf[lb_addr];
   assign pair_max = fmax(pair_reg, data_in);
   assign win_max  = fmax(lb_rd, pair_max);
   assign odd_col  = col_cnt_reg[0];
   assign odd_row  = row_cnt_reg[0];
   assign last_col = (col_cnt_reg == LAST_IDX);
   assign last_row = (row_cnt_reg == LAST_IDX);

   // Raster position counters; hold whenever no pixel is presented.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         col_cnt_reg <= '0;
         row_cnt_reg <= '0;
      end else if (valid_in) begin
         if (last_col) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= last_row ? '0 : row_cnt_reg + 1'b1;
         end else begin
            col_cnt_reg <= col_cnt_reg + 1'b1;
         end
      end
   end

   // Capture the left pixel of each horizontal pair.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         pair_reg <= '0;
      else if (valid_in && !odd_col)
         pair_reg <= data_in;
   end

   // Even rows store their pair maxima; contents need no reset because each
   // entry is rewritten before an odd row reads it.
   always_ff @(posedge Clk) begin
      if (valid_in && odd_col && !odd_row)
         linebuf[lb_addr] <= pair_max;
   end

   // Emit one pooled pixel when an odd row closes a window; data holds otherwise.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else if (valid_in && odd_col && odd_row) begin
         data_out  <= win_max;
         valid_out <= 1'b1;
      end else begin
         valid_out <= 1'b0;
      end
   end

`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
   // Flag the final pooled pixel of the frame alongside its valid_out.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         frame_done <= 1'b0;
      else
         frame_done <= valid_in && last_col && last_row;
   end
`endif

endmodule

// File: tb/tb_layer_maxpool2x2.sv
// Bench for layer_maxpool2x2: a 4x4 instance for directed/random frames and
// a 64x64 instance for back-to-back ramp frames. The reference model picks,
// per window, the earliest-arriving pixel with the greatest numeric order
// key (ordering both zeros equal), independent of the design's structure.
module tb_layer_maxpool2x2;

   localparam int NS = 4;
   localparam int NL = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din_s = '0, din_l = '0;
   logic        vin_s = 1'b0, vin_l = 1'b0;
   logic [31:0] dout_s, dout_l;
   logic        vout_s, vout_l;
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
   logic        fd_s, fd_l;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] img [0:NS-1][0:NS-1];
   logic [31:0] last_s = '0;

   always #5 clk = ~clk;

   layer_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(NS)) dut_s (
      .Clk(clk), .Rst(rst_n), .data_in(din_s), .valid_in(vin_s),
      .data_out(dout_s), .valid_out(vout_s)
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
      , .frame_done(fd_s)
`endif
   );

   layer_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(NL)) dut_l (
      .Clk(clk), .Rst(rst_n), .data_in(din_l), .valid_in(vin_l),
      .data_out(dout_l), .valid_out(vout_l)
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
      , .frame_done(fd_l)
`endif
   );

   // Numeric order key: positives by magnitude, negatives below zero, +0 == -0.
   function automatic longint order_key(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   // Max of the 2x2 window whose bottom-right pixel is (r,c); earliest wins ties.
   function automatic logic [31:0] window_max(input int r, input int c);
      logic [31:0] cand [4];
      logic [31:0] best;
      cand[0] = img[r-1][c-1];
      cand[1] = img[r-1][c];
      cand[2] = img[r][c-1];
      cand[3] = img[r][c];
      best = cand[0];
      for (int k = 1; k < 4; k++)
         if (order_key(cand[k]) > order_key(best)) best = cand[k];
      return best;
   endfunction

   // Exact single-precision encoding of a non-negative integer below 2^24.
   function automatic logic [31:0] int_to_float(input int unsigned v);
      int p;
      logic [31:0] sh;
      if (v == 0) return 32'h0;
      p = 31;
      while (v[p] == 1'b0) p--;
      sh = v << (23 - p);
      return {1'b0, 8'(127 + p), sh[22:0]};
   endfunction

   task automatic load_test1_frame();
      logic [31:0] row0 [4];
      logic [31:0] row1 [4];
      row0 = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000};
      row1 = '{32'h40400000, 32'h3F800000, 32'hC0400000, 32'hBF000000};
      for (int c = 0; c < NS; c++) begin
         img[0][c] = row0[c];
         img[1][c] = row1[c];
         img[2][c] = row0[c];
         img[3][c] = row1[c];
      end
   endtask

   // Streams img through the small instance and checks every cycle.
   task automatic test_frame_small(input string name, input int gap_fixed, input bit gap_rand);
      logic [31:0] exp_d;
      int gaps;
      for (int r = 0; r < NS; r++) begin
         for (int c = 0; c < NS; c++) begin
            gaps = gap_rand ? int'($urandom_range(0, 2)) : gap_fixed;
            for (int g = 0; g < gaps; g++) begin
               vin_s = 1'b0;
               din_s = $urandom;
               @(posedge clk); #1;
               vectors++;
               if (vout_s !== 1'b0 || dout_s !== last_s) begin
                  miscompares++;
                  $display("FAIL %s idle r=%0d c=%0d: got v=%b d=%h, want v=0 d=%h",
                           name, r, c, vout_s, dout_s, last_s);
               end
            end
            vin_s = 1'b1;
            din_s = img[r][c];
            @(posedge clk); #1;
            vectors++;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
               exp_d = window_max(r, c);
               if (vout_s !== 1'b1 || dout_s !== exp_d) begin
                  miscompares++;
                  $display("FAIL %s out r=%0d c=%0d: got v=%b d=%h, want v=1 d=%h",
                           name, r, c, vout_s, dout_s, exp_d);
               end
               last_s = exp_d;
            end else begin
               if (vout_s !== 1'b0 || dout_s !== last_s) begin
                  miscompares++;
                  $display("FAIL %s noout r=%0d c=%0d: got v=%b d=%h, want v=0 d=%h",
                           name, r, c, vout_s, dout_s, last_s);
               end
            end
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
            vectors++;
            if (fd_s !== ((r == NS-1) && (c == NS-1))) begin
               miscompares++;
               $display("FAIL %s frame_done r=%0d c=%0d: got %b", name, r, c, fd_s);
            end
`endif
         end
      end
      vin_s = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      vectors++;
      if (vout_s !== 1'b0 || dout_s !== 32'h0 || vout_l !== 1'b0 || dout_l !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: got vs=%b ds=%h vl=%b dl=%h, want all 0",
                  vout_s, dout_s, vout_l, dout_l);
      end
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
      vectors++;
      if (fd_s !== 1'b0 || fd_l !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_frame_done: got %b %b, want 0 0", fd_s, fd_l);
      end
`endif
      rst_n = 1'b1;
      last_s = '0;
   endtask

   task automatic test_basic();
      load_test1_frame();
      test_frame_small("basic", 0, 1'b0);
   endtask

   task automatic test_gaps();
      load_test1_frame();
      test_frame_small("gaps", 3, 1'b0);
   endtask

   task automatic test_ties();
      for (int r = 0; r < NS; r++)
         for (int c = 0; c < NS; c++)
            img[r][c] = $urandom;
      img[0][0] = 32'h80000000; img[0][1] = 32'h00000000;
      img[1][0] = 32'h00000000; img[1][1] = 32'h80000000;
      img[0][2] = 32'h41200000; img[0][3] = 32'h41200000;
      img[1][2] = 32'h41200000; img[1][3] = 32'h41200000;
      test_frame_small("ties", 0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 6; k++) pool[k] = $urandom;
         pool[0] = 32'h00000000;
         pool[1] = 32'h80000000;
         pool[2] = {~pool[3][31], pool[3][30:0]};
         for (int r = 0; r < NS; r++)
            for (int c = 0; c < NS; c++)
               img[r][c] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : $urandom;
         test_frame_small("random", 0, 1'b1);
      end
   endtask

   task automatic test_mid_frame_reset();
      for (int k = 0; k < 5; k++) begin
         vin_s = 1'b1;
         din_s = $urandom;
         @(posedge clk); #1;
         vectors++;
         if (vout_s !== 1'b0) begin
            miscompares++;
            $display("FAIL prereset_pixel%0d: got v=%b, want 0", k, vout_s);
         end
      end
      vin_s = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (vout_s !== 1'b0 || dout_s !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b d=%h, want v=0 d=00000000", vout_s, dout_s);
      end
      vin_s = 1'b1;
      din_s = 32'h7F000000;
      @(posedge clk); @(posedge clk); #1;
      vectors++;
      if (vout_s !== 1'b0 || dout_s !== 32'h0) begin
         miscompares++;
         $display("FAIL held_reset: got v=%b d=%h, want v=0 d=00000000", vout_s, dout_s);
      end
      vin_s = 1'b0;
      rst_n = 1'b1;
      last_s = '0;
      load_test1_frame();
      test_frame_small("post_reset", 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      int pulses;
      for (int f = 0; f < 2; f++) begin
         pulses = 0;
         for (int r = 0; r < NL; r++) begin
            for (int c = 0; c < NL; c++) begin
               vin_l = 1'b1;
               din_l = int_to_float(r * NL + c);
               @(posedge clk); #1;
               vectors++;
               if ((r % 2 == 1) && (c % 2 == 1)) begin
                  exp_d = int_to_float(r * NL + c);
                  if (vout_l === 1'b1) pulses++;
                  if (vout_l !== 1'b1 || dout_l !== exp_d) begin
                     miscompares++;
                     $display("FAIL ramp f=%0d r=%0d c=%0d: got v=%b d=%h, want v=1 d=%h",
                              f, r, c, vout_l, dout_l, exp_d);
                  end
               end else if (vout_l !== 1'b0) begin
                  miscompares++;
                  $display("FAIL ramp_noout f=%0d r=%0d c=%0d: got v=%b, want 0", f, r, c, vout_l);
               end
`ifdef LAYER_MAXPOOL_FRAME_DONE_EN
               vectors++;
               if (fd_l !== ((r == NL-1) && (c == NL-1))) begin
                  miscompares++;
                  $display("FAIL ramp_frame_done f=%0d r=%0d c=%0d: got %b", f, r, c, fd_l);
               end
`endif
            end
         end
         vectors++;
         if (pulses != (NL/2) * (NL/2)) begin
            miscompares++;
            $display("FAIL ramp_count f=%0d: got %0d pulses, want %0d", f, pulses, (NL/2) * (NL/2));
         end
      end
      vin_l = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_ties();
      test_random();
      test_mid_frame_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
